mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Purpose: Y86 memory-stage initiator; decodes icode, range-checks the address and drives the data memory.
// Latency: start edge to done is ACC_CYCLES+1 cycles for a read/write, 1 cycle for no-access or address error.
// Backpressure: none; start is taken only in IDLE, and start while busy (or during done) is dropped.
// Optional: define MEM_STATS_EN to add rd_count/wr_count completed-access counters.
module mem_stage_ctrl #(
  parameter logic [63:0] ADDR_MIN   = 64'd1,
  parameter logic [63:0] ADDR_MAX   = 64'd20,
  parameter int          ACC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_valM,
  output logic [63:0] valM,
  output logic        done,
  output logic        busy,
  output logic        dmem_error
`ifdef MEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] addr_nxt, data_nxt, valm_nxt;
  logic        rd_nxt, wr_nxt, done_nxt, busy_nxt, err_nxt;

  logic        dec_rd, dec_wr;
  logic [63:0] dec_addr, dec_data;
  logic        in_range;

  // Decode the incoming request: direction, address source and write-data source.
  always_comb begin
    dec_rd   = 1'b0;
    dec_wr   = 1'b0;
    dec_addr = valE;
    dec_data = valA;
    case (icode)
      4'h4: dec_wr = 1'b1;
      4'h5: dec_rd = 1'b1;
      4'h8: begin dec_wr = 1'b1; dec_data = valP; end
      4'h9: begin dec_rd = 1'b1; dec_addr = valA; end
      4'hA: dec_wr = 1'b1;
      4'hB: begin dec_rd = 1'b1; dec_addr = valA; end
      default: ;
    endcase
  end

  // Full-width unsigned compare, so huge or zero addresses never wrap into range.
  assign in_range = (dec_addr >= ADDR_MIN) && (dec_addr <= ADDR_MAX);

  // Next-state and next registered-output values; everything defaults to hold.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = mem_addr;
    data_nxt  = mem_data;
    valm_nxt  = valM;
    rd_nxt    = mem_read;
    wr_nxt    = mem_write;
    done_nxt  = 1'b0;
    busy_nxt  = busy;
    err_nxt   = dmem_error;
    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          valm_nxt = '0;
          err_nxt  = 1'b0;
          busy_nxt = 1'b1;
          if ((dec_rd || dec_wr) && in_range) begin
            addr_nxt  = dec_addr;
            data_nxt  = dec_data;
            rd_nxt    = dec_rd;
            wr_nxt    = dec_wr;
            cnt_nxt   = CNT_INIT;
            state_nxt = S_ACCESS;
          end else begin
            // Out-of-range memory op flags an error; non-memory op just completes.
            err_nxt   = dec_rd || dec_wr;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_ACCESS: begin
        // Write strobe lives only in the first ACCESS cycle so memory commits once.
        wr_nxt = 1'b0;
        if (cnt == 4'd0) begin
          if (mem_read) valm_nxt = mem_valM;
          rd_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered outputs; reset drops strobes and discards any access in flight.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      mem_addr   <= '0;
      mem_data   <= '0;
      valM       <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      dmem_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mem_addr   <= addr_nxt;
      mem_data   <= data_nxt;
      valM       <= valm_nxt;
      mem_read   <= rd_nxt;
      mem_write  <= wr_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      dmem_error <= err_nxt;
    end
  end

`ifdef MEM_STATS_EN
  // Count completed accesses on the edge leaving ACCESS; an ACCESS that is not a read is a write.
  always_ff @(posedge clk) begin
    if (res) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (state == S_ACCESS && cnt == 4'd0) begin
      if (mem_read) rd_count <= rd_count + 32'd1;
      else          wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: two instances (ACC_CYCLES=1 and 3) share stimulus, each with its own memory model.
// Expected results are queued per instance when a request is issued; a negedge monitor pops on done.
// Strobe address/data, strobe cycle counts and start-to-done latency are checked by the monitor.
module tb_mem_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res1, res3, start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;

  logic [63:0] ma1, md1, vm1, mv1, ma3, md3, vm3, mv3;
  logic        mr1, mw1, dn1, bz1, er1, mr3, mw3, dn3, bz3, er3;
`ifdef MEM_STATS_EN
  logic [31:0] rc1, wc1, rc3, wc3;
`endif

  mem_stage_ctrl #(.ADDR_MIN(64'd1), .ADDR_MAX(64'd20), .ACC_CYCLES(1)) u1 (
    .clk(clk), .res(res1), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .mem_addr(ma1), .mem_data(md1), .mem_read(mr1), .mem_write(mw1),
    .mem_valM(mv1), .valM(vm1), .done(dn1), .busy(bz1), .dmem_error(er1)
`ifdef MEM_STATS_EN
    , .rd_count(rc1), .wr_count(wc1)
`endif
  );

  mem_stage_ctrl #(.ADDR_MIN(64'd1), .ADDR_MAX(64'd20), .ACC_CYCLES(3)) u3 (
    .clk(clk), .res(res3), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .mem_addr(ma3), .mem_data(md3), .mem_read(mr3), .mem_write(mw3),
    .mem_valM(mv3), .valM(vm3), .done(dn3), .busy(bz3), .dmem_error(er3)
`ifdef MEM_STATS_EN
    , .rd_count(rc3), .wr_count(wc3)
`endif
  );

  // Data memory models: combinational read, write on the clock edge.
  logic [63:0] mem1 [0:31];
  logic [63:0] mem3 [0:31];
  initial for (int i = 0; i < 32; i++) begin mem1[i] = '0; mem3[i] = '0; end
  always @(posedge clk) begin
    if (mw1) mem1[ma1[4:0]] <= md1;
    if (mw3) mem3[ma3[4:0]] <= md3;
  end
  assign mv1 = mr1 ? mem1[ma1[4:0]] : 64'd0;
  assign mv3 = mr3 ? mem3[ma3[4:0]] : 64'd0;

  // kind: 0 = no strobe expected, 1 = read, 2 = write
  typedef struct {
    logic [1:0]  kind;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] vm;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int nchk = 0, nerr = 0, cyc = 0;
  int t0[2], rdc[2], wrc[2], exp_rd[2], exp_wr[2];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  task automatic mon_step(input int d, input int acc, input logic st_ok, input logic rd, input logic wr,
                          input logic dn, input logic [63:0] addr, input logic [63:0] data,
                          input logic [63:0] vm, input logic er);
    exp_t e;
    int   n;
    if (st_ok) begin t0[d] = cyc; rdc[d] = 0; wrc[d] = 0; end
    n = (d == 0) ? q1.size() : q3.size();
    if (rd || wr) begin
      if (rd) rdc[d]++;
      if (wr) wrc[d]++;
      if (n == 0) begin
        nchk++; nerr++;
        $display("FAIL dut%0d strobe: got strobe with addr %0h expected none", d, addr);
      end else begin
        if (d == 0) e = q1[0]; else e = q3[0];
        chk($sformatf("dut%0d strobe addr", d), addr, e.addr);
        if (wr) chk($sformatf("dut%0d write data", d), data, e.data);
      end
    end
    if (dn) begin
      if (n == 0) begin
        nchk++; nerr++;
        $display("FAIL dut%0d done: got unexpected done expected none", d);
      end else begin
        if (d == 0) e = q1.pop_front(); else e = q3.pop_front();
        chk($sformatf("dut%0d valM", d), vm, e.vm);
        chk($sformatf("dut%0d dmem_error", d), 64'(er), 64'(e.err));
        chk($sformatf("dut%0d latency", d), 64'(cyc - t0[d]), 64'((e.kind != 2'd0) ? acc + 1 : 1));
        chk($sformatf("dut%0d read cycles", d), 64'(rdc[d]), 64'((e.kind == 2'd1) ? acc : 0));
        chk($sformatf("dut%0d write cycles", d), 64'(wrc[d]), 64'((e.kind == 2'd2) ? 1 : 0));
      end
    end
  endtask

  // Monitor: samples away from the active edge and scores both instances.
  always @(negedge clk) begin
    cyc++;
    mon_step(0, 1, start && !bz1 && !dn1 && !res1, mr1, mw1, dn1, ma1, md1, vm1, er1);
    mon_step(1, 3, start && !bz3 && !dn3 && !res3, mr3, mw3, dn3, ma3, md3, vm3, er3);
  end

  task automatic push_exp(input logic [1:0] kind, input logic [63:0] addr, input logic [63:0] data,
                          input logic [63:0] vm, input logic err);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.vm = vm; e.err = err;
    q1.push_back(e);
    q3.push_back(e);
    for (int d = 0; d < 2; d++) begin
      if (kind == 2'd1) exp_rd[d]++;
      if (kind == 2'd2) exp_wr[d]++;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bz1 && !dn1 && !bz3 && !dn3) return;
    end
    nchk++; nerr++;
    $display("FAIL idle wait: got still busy after 60 cycles expected idle");
  endtask

  task automatic go(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    @(posedge clk); #1;
    icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
  endtask

  task automatic chk_zero(input string n, input logic [63:0] a, input logic [63:0] dt, input logic [63:0] v,
                          input logic r, input logic w, input logic dn, input logic b, input logic er);
    chk({n, " mem_addr"}, a, 64'd0);
    chk({n, " mem_data"}, dt, 64'd0);
    chk({n, " valM"}, v, 64'd0);
    chk({n, " mem_read"}, 64'(r), 64'd0);
    chk({n, " mem_write"}, 64'(w), 64'd0);
    chk({n, " done"}, 64'(dn), 64'd0);
    chk({n, " busy"}, 64'(b), 64'd0);
    chk({n, " dmem_error"}, 64'(er), 64'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin t0[d] = 0; rdc[d] = 0; wrc[d] = 0; exp_rd[d] = 0; exp_wr[d] = 0; end
    res1 = 1'b1; res3 = 1'b1; start = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst dut0", ma1, md1, vm1, mr1, mw1, dn1, bz1, er1);
    chk_zero("rst dut1", ma3, md3, vm3, mr3, mw3, dn3, bz3, er3);
    @(posedge clk); #1;
    res1 = 1'b0; res3 = 1'b0;

    // Write then read back, including the range boundaries.
    push_exp(2'd2, 64'd5, 64'hDEAD, 64'd0, 1'b0);      go(4'h4, 64'd5, 64'hDEAD, 64'd0);
    push_exp(2'd1, 64'd5, 64'd0, 64'hDEAD, 1'b0);      go(4'h5, 64'd5, 64'd0, 64'd0);
    push_exp(2'd2, 64'd20, 64'h1234, 64'd0, 1'b0);     go(4'hA, 64'd20, 64'h1234, 64'd0);
    push_exp(2'd1, 64'd20, 64'd0, 64'h1234, 1'b0);     go(4'hB, 64'd0, 64'd20, 64'd0);
    push_exp(2'd0, 64'd0, 64'd0, 64'd0, 1'b1);         go(4'hB, 64'd5, 64'd21, 64'd0);
    push_exp(2'd0, 64'd0, 64'd0, 64'd0, 1'b1);         go(4'hB, 64'd5, 64'd0, 64'd0);
    push_exp(2'd0, 64'd0, 64'd0, 64'd0, 1'b1);         go(4'hB, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    push_exp(2'd0, 64'd0, 64'd0, 64'd0, 1'b0);         go(4'h6, 64'd5, 64'd5, 64'd0);
    push_exp(2'd1, 64'd1, 64'd0, 64'd0, 1'b0);         go(4'h5, 64'd1, 64'd0, 64'd0);
    // call writes valP at valE; ret reads at valA.
    push_exp(2'd2, 64'd7, 64'h40, 64'd0, 1'b0);        go(4'h8, 64'd7, 64'h99, 64'h40);
    push_exp(2'd1, 64'd7, 64'd0, 64'h40, 1'b0);        go(4'h9, 64'd3, 64'd7, 64'd0);

    // Extra start pulses during ACCESS and during done must be dropped.
    push_exp(2'd1, 64'd7, 64'd0, 64'h40, 1'b0);
    @(posedge clk); #1;
    icode = 4'h5; valE = 64'd7; valA = 64'd0; start = 1'b1;
    @(posedge clk); #1;
    icode = 4'h4; valE = 64'd3; valA = 64'h99;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    push_exp(2'd1, 64'd3, 64'd0, 64'd0, 1'b0);         go(4'h5, 64'd3, 64'd0, 64'd0);

    // Reset the 3-cycle instance in its second ACCESS cycle of a read; the 1-cycle one completes.
    push_exp(2'd1, 64'd5, 64'd0, 64'hDEAD, 1'b0);
    @(posedge clk); #1;
    icode = 4'h9; valE = 64'd0; valA = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    res3 = 1'b1;
    @(posedge clk); #1;
    res3 = 1'b0;
    void'(q3.pop_front());
    exp_rd[1] = 0; exp_wr[1] = 0;
    @(negedge clk);
    chk_zero("midreset dut1", ma3, md3, vm3, mr3, mw3, dn3, bz3, er3);
    wait_idle();
    repeat (6) @(negedge clk);

`ifdef MEM_STATS_EN
    chk("dut0 rd_count", 64'(rc1), 64'(exp_rd[0]));
    chk("dut0 wr_count", 64'(wc1), 64'(exp_wr[0]));
    chk("dut1 rd_count", 64'(rc3), 64'(exp_rd[1]));
    chk("dut1 wr_count", 64'(wc3), 64'(exp_wr[1]));
    push_exp(2'd2, 64'd9, 64'h77, 64'd0, 1'b0);        go(4'h4, 64'd9, 64'h77, 64'd0);
    chk("dut1 wr_count after write", 64'(wc3), 64'(exp_wr[1]));
    @(posedge clk); #1;
    res1 = 1'b1;
    @(posedge clk); #1;
    res1 = 1'b0;
    @(negedge clk);
    chk("dut0 rd_count cleared", 64'(rc1), 64'd0);
    chk("dut0 wr_count cleared", 64'(wc1), 64'd0);
`endif

    chk("dut0 queue drained", 64'(q1.size()), 64'd0);
    chk("dut1 queue drained", 64'(q3.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
